// File: rtl/des_feistel_decrypt_iter.sv
// Iterative DES decryptor: one Feistel round per clock, subkeys applied K16 down to K1.
// Optional macro DES_DEC_KEY_LATCH_EN captures all subkeys at the input handshake.
module des_feistel_decrypt_iter #(
  parameter bit ZERO_IDLE_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [47:0] K1,
  input  logic [47:0] K2,
  input  logic [47:0] K3,
  input  logic [47:0] K4,
  input  logic [47:0] K5,
  input  logic [47:0] K6,
  input  logic [47:0] K7,
  input  logic [47:0] K8,
  input  logic [47:0] K9,
  input  logic [47:0] K10,
  input  logic [47:0] K11,
  input  logic [47:0] K12,
  input  logic [47:0] K13,
  input  logic [47:0] K14,
  input  logic [47:0] K15,
  input  logic [47:0] K16,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Permutation tables use DES numbering: bit 1 is the MSB.
  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each S-box is 64 nibbles, entry {row,col} = 0 at the MSB end.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] des_ip(input logic [63:0] v);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o = {o[62:0], v[6'(64 - IP_TBL[6'(i)])]};
    return o;
  endfunction

  function automatic logic [63:0] des_ip_inv(input logic [63:0] v);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o = {o[62:0], v[6'(64 - FP_TBL[6'(i)])]};
    return o;
  endfunction

  function automatic logic [31:0] f_function(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  six;
    logic [5:0]  idx;
    x = '0;
    for (int i = 0; i < 48; i++) x = {x[46:0], r[5'(32 - E_TBL[6'(i)])]};
    x = x ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      six = x[47:42];
      x   = {x[41:0], 6'b0};
      idx = {six[5], six[0], six[4:1]};
      s   = {s[27:0], SBOX[3'(j)][{~idx, 2'b00} +: 4]};
    end
    p = '0;
    for (int i = 0; i < 32; i++) p = {p[30:0], s[5'(32 - P_TBL[5'(i)])]};
    return p;
  endfunction

  logic [1:0]  r_state;
  logic [3:0]  r_rnd;
  logic [31:0] r_l;
  logic [31:0] r_r;
  logic        r_out_valid;
  logic [63:0] r_out_data;

  logic        w_accept;
  logic [63:0] w_ip;
  logic [47:0] w_round_key;
  logic [31:0] w_f;
  logic [31:0] w_l_next;
  logic [31:0] w_r_next;
  logic [47:0] w_key_live [16];

  // Decryption order: slot n holds the key for round counter value n.
  assign w_key_live = '{K16, K15, K14, K13, K12, K11, K10, K9,
                        K8,  K7,  K6,  K5,  K4,  K3,  K2,  K1};

  assign w_accept = (r_state == ST_IDLE) && in_valid;

`ifdef DES_DEC_KEY_LATCH_EN
  logic [47:0] r_keys [16];

  // NOTE: the key bank is a plain register array, so it can and does take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_keys <= '{default: '0};
    end else if (w_accept) begin
      r_keys <= w_key_live;
    end
  end

  assign w_round_key = r_keys[r_rnd];
`else
  assign w_round_key = w_key_live[r_rnd];
`endif

  assign w_ip     = des_ip(in_data);
  assign w_f      = f_function(r_r, w_round_key);
  assign w_l_next = r_r;
  assign w_r_next = r_l ^ w_f;

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rnd       <= 4'd0;
      r_l         <= '0;
      r_r         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_l     <= w_ip[63:32];
            r_r     <= w_ip[31:0];
            r_rnd   <= 4'd0;
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_l   <= w_l_next;
          r_r   <= w_r_next;
          r_rnd <= r_rnd + 4'd1;
          // Last round: halves are swapped before the final permutation.
          if (r_rnd == 4'd15) begin
            r_out_data  <= des_ip_inv({w_r_next, w_l_next});
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
            if (ZERO_IDLE_OUT) r_out_data <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_ROUND);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_des_feistel_decrypt_iter.sv
// Directed bench for des_feistel_decrypt_iter: known DES vectors, back-pressure,
// reset abort and encrypt/decrypt round trips against a software DES model.
module tb_des_feistel_decrypt_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [47:0] k [16];
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  des_feistel_decrypt_iter dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .K1(k[0]),   .K2(k[1]),   .K3(k[2]),   .K4(k[3]),
    .K5(k[4]),   .K6(k[5]),   .K7(k[6]),   .K8(k[7]),
    .K9(k[8]),   .K10(k[9]),  .K11(k[10]), .K12(k[11]),
    .K13(k[12]), .K14(k[13]), .K15(k[14]), .K16(k[15]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int IPT [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FPT [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int ET [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int PT [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Software key schedule; drives the DUT subkey inputs (k[0] is K1).
  task automatic key_schedule(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sub;
    cd = '0;
    for (int i = 0; i < 56; i++) cd = {cd[54:0], key[6'(64 - PC1[i])]};
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd  = {c, d};
      sub = '0;
      for (int i = 0; i < 48; i++) sub = {sub[46:0], cd[6'(56 - PC2[i])]};
      k[r] = sub;
    end
  endtask

  function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] sk);
    logic [47:0] e;
    logic [31:0] s, p;
    logic [5:0]  b;
    int          row, col;
    for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - ET[i])];
    e = e ^ sk;
    for (int j = 0; j < 8; j++) begin
      b   = e[6'(47 - 6 * j) -: 6];
      row = {b[5], b[0]};
      col = int'(b[4:1]);
      s[5'(31 - 4 * j) -: 4] = 4'(SB[j] >> (4 * (63 - (row * 16 + col))));
    end
    for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - PT[i])];
    return p;
  endfunction

  function automatic logic [63:0] model_encrypt(input logic [63:0] pt);
    logic [63:0] t, o;
    logic [31:0] l, r, nr;
    for (int i = 0; i < 64; i++) t[6'(63 - i)] = pt[6'(64 - IPT[i])];
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < 16; i++) begin
      nr = l ^ model_f(r, k[i]);
      l  = r;
      r  = nr;
    end
    t = {r, l};
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = t[6'(64 - FPT[i])];
    return o;
  endfunction

  // Accept one block, measure latency, optionally stall, then complete the handshake.
  task automatic run_block(input logic [63:0] ct, input logic [63:0] exp, input int stall,
                           input bit scramble, input string tag);
    int lat;
    bit stable;
    in_valid = 1'b1;
    in_data  = ct;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (scramble) for (int i = 0; i < 16; i++) k[i] = 48'({$urandom, $urandom});
      in_data = {$urandom, $urandom};
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd16);
    check({tag, "_data"}, out_data, exp);
    stable = 1'b1;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      @(negedge clk);
      if (out_data !== exp || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    if (stall > 0) check({tag, "_stall_stable"}, 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_cleared"}, 64'(out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    check({tag, "_zero_idle"}, out_data, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pt, ct;
    bit          seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    for (int i = 0; i < 16; i++) k[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    key_schedule(64'h133457799BBCDFF1);
    run_block(64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, 1'b0, "v1");

    key_schedule(64'h0101010101010101);
    run_block(64'h8CA64DE9C1B123A7, 64'h0000000000000000, 0, 1'b0, "v2");

    key_schedule(64'h133457799BBCDFF1);
    run_block(64'h85E813540F0AB405, 64'h0123456789ABCDEF, 20, 1'b0, "stall");

    // Abort a block at round 8 with an asynchronous reset.
    in_valid = 1'b1;
    in_data  = 64'h85E813540F0AB405;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    run_block(64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, 1'b0, "after_abort");

    for (int b = 0; b < 10; b++) begin
      key_schedule({$urandom, $urandom});
      pt = {$urandom, $urandom};
      ct = model_encrypt(pt);
      run_block(ct, pt, int'($urandom_range(0, 3)), 1'b0, "rand");
    end

`ifdef DES_DEC_KEY_LATCH_EN
    key_schedule(64'h133457799BBCDFF1);
    run_block(64'h85E813540F0AB405, 64'h0123456789ABCDEF, 2, 1'b1, "latch");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
